average_window: RTL and testbench

- Parametrised sliding-window mean of an unsigned sample stream. Successor to the fixed 4-bit averaging block.
- Keeps the last 2^LOG_DEPTH loaded samples in a ring buffer and a running sum.
- Publishes a registered mean, a window-full flag and a registered threshold-compare bit y.
- Sits between the sample source (which asserts x_load) and downstream control that consumes y.

---
 rtl/average_window_if.sv | 23 ++
 rtl/average_window.sv | 93 +++++++++
 tb/tb_average_window.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/average_window_if.sv
// Sample/threshold inputs and mean/flag outputs of the sliding-window averager.
// The source side uses master, average_window uses slave.
interface average_window_if #(
    parameter int W = 4
) ();
    logic         x_load;
    logic [W-1:0] x;
    logic         x_clr;
    logic [W-1:0] thr;
    logic [W-1:0] y_avg;
    logic         y_valid;
    logic         y;

    modport master (
        output x_load, x, x_clr, thr,
        input  y_avg, y_valid, y
    );

    modport slave (
        input  x_load, x, x_clr, thr,
        output y_avg, y_valid, y
    );
endinterface

// File: rtl/average_window.sv
// Sliding-window mean over the last 2^LOG_DEPTH samples with threshold flag.
// Define AVERAGE_WINDOW_ROUND_EN to round the mean half-up instead of flooring.
module average_window #(
    parameter int W         = 4,
    parameter int LOG_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    average_window_if.slave  bus
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int SW    = W + LOG_DEPTH;

    localparam logic [LOG_DEPTH:0]   FULL    = (LOG_DEPTH+1)'(DEPTH);
    localparam logic [LOG_DEPTH:0]   CNT_ONE = (LOG_DEPTH+1)'(1);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE = LOG_DEPTH'(1);

    logic [W-1:0]         ring_q [DEPTH];
    logic [W-1:0]         ring_d [DEPTH];
    logic [SW-1:0]        sum_q, sum_d, sum_next;
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic [W-1:0]         avg_q, avg_d, avg_next;
    logic                 valid_q, valid_d;
    logic                 y_q, y_d;

    // Evicted slot is still zero while filling, so the subtract is harmless.
    assign sum_next = sum_q + SW'(bus.x) - SW'(ring_q[wr_ptr_q]);

`ifdef AVERAGE_WINDOW_ROUND_EN
    localparam logic [SW:0] HALF = (SW+1)'(DEPTH / 2);

    logic [W:0] avg_wide;

    assign avg_wide = (W+1)'(({1'b0, sum_next} + HALF) >> LOG_DEPTH);
    assign avg_next = avg_wide[W] ? '1 : avg_wide[W-1:0];
`else
    assign avg_next = sum_next[SW-1:LOG_DEPTH];
`endif

    always_comb begin
        ring_d   = ring_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        avg_d    = avg_q;
        valid_d  = valid_q;
        y_d      = y_q;
        if (bus.x_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                ring_d[i] = '0;
            end
            sum_d    = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            avg_d    = '0;
            valid_d  = 1'b0;
            y_d      = 1'b0;
        end else if (bus.x_load) begin
            ring_d[wr_ptr_q] = bus.x;
            sum_d    = sum_next;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = (count_q == FULL) ? count_q : count_q + CNT_ONE;
            avg_d    = avg_next;
            valid_d  = (count_d == FULL);
            y_d      = (avg_next >= bus.thr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ring_q   <= '{default: '0};
            sum_q    <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            avg_q    <= '0;
            valid_q  <= 1'b0;
            y_q      <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            avg_q    <= avg_d;
            valid_q  <= valid_d;
            y_q      <= y_d;
        end
    end

    assign bus.y_avg   = avg_q;
    assign bus.y_valid = valid_q;
    assign bus.y       = y_q;
endmodule

// File: tb/tb_average_window.sv
// Bench for average_window (W=4, LOG_DEPTH=2): directed table plus
// a scoreboarded random stream checked against a window-sum model.
module tb_average_window;
    typedef struct {
        logic       rst;
        logic       clr;
        logic       load;
        logic [3:0] x;
        logic [3:0] thr;
        logic [3:0] avg;
        logic       valid;
        logic       y;
    } vec_t;

    typedef struct {
        logic [3:0] avg;
        logic       valid;
        logic       y;
    } exp_t;

`ifdef AVERAGE_WINDOW_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    vec_t vecs[$];
    exp_t sb[$];

    average_window_if #(.W(4)) bus ();

    average_window #(.W(4), .LOG_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] pick(input logic [3:0] t,
                                        input logic [3:0] r);
        return RND ? r : t;
    endfunction

    function automatic void add(input logic r, input logic c,
                                input logic l, input logic [3:0] x,
                                input logic [3:0] thr,
                                input logic [3:0] avg,
                                input logic v, input logic y);
        vec_t e;
        e.rst = r; e.clr = c; e.load = l; e.x = x; e.thr = thr;
        e.avg = avg; e.valid = v; e.y = y;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        rst        = v.rst;
        bus.x_clr  = v.clr;
        bus.x_load = v.load;
        bus.x      = v.x;
        bus.thr    = v.thr;
        e.avg = v.avg; e.valid = v.valid; e.y = v.y;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 0, 1);
        end else begin
            got = sb.pop_front();
            check({tag, " y_avg"}, int'(bus.y_avg), int'(got.avg));
            check({tag, " y_valid"}, int'(bus.y_valid), int'(got.valid));
            check({tag, " y"}, int'(bus.y), int'(got.y));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] m_ring[4];
        int         m_ptr;
        int         m_cnt;
        vec_t       v;
        int         s;
        int         a;

        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.x_clr = 1'b0; bus.x_load = 1'b0;
        bus.x = '0; bus.thr = 4'd7;

        // reset and idle hold
        add(1, 0, 0, 0, 7, 0, 0, 0);
        add(1, 0, 0, 0, 7, 0, 0, 0);
        add(0, 0, 0, 0, 7, 0, 0, 0);
        add(0, 0, 0, 0, 7, 0, 0, 0);
        // fill 5,7,4,8
        add(0, 0, 1, 5, 7, 1, 0, 0);
        add(0, 0, 1, 7, 7, 3, 0, 0);
        add(0, 0, 1, 4, 7, 4, 0, 0);
        add(0, 0, 1, 8, 7, 6, 1, 0);
        // wrap: sum 34 then 27
        add(0, 0, 1, 15, 7, pick(8, 9), 1, 1);
        add(0, 0, 1, 0, 7, pick(6, 7), 1, RND);
        // saturate with 15s: sums 38,45,45,60
        add(0, 0, 1, 15, 7, pick(9, 10), 1, 1);
        add(0, 0, 1, 15, 7, 11, 1, 1);
        add(0, 0, 1, 15, 7, 11, 1, 1);
        add(0, 0, 1, 15, 7, 15, 1, 1);
        for (int i = 0; i < 10; i++) begin
            add(0, 0, 1, 15, 7, 15, 1, 1);
        end
        // clear wins over load; next load of 8 is partial
        add(0, 1, 1, 9, 7, 0, 0, 0);
        add(0, 0, 1, 8, 7, 2, 0, 0);
        // gaps, thr change while idle
        add(0, 1, 0, 0, 7, 0, 0, 0);
        add(0, 0, 1, 4, 7, 1, 0, 0);
        add(0, 0, 0, 0, 7, 1, 0, 0);
        add(0, 0, 0, 0, 3, 1, 0, 0);
        add(0, 0, 1, 4, 3, 2, 0, 0);
        add(0, 0, 1, 4, 3, 3, 0, 1);
        add(0, 0, 1, 4, 3, 4, 1, 1);
        add(0, 0, 0, 0, 15, 4, 1, 1);
        // reset mid-stream with load discards everything
        add(1, 0, 1, 9, 7, 0, 0, 0);
        add(0, 0, 1, 12, 3, 3, 0, 1);
        add(1, 0, 0, 0, 7, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // random stream against a window model
        for (int i = 0; i < 4; i++) m_ring[i] = '0;
        m_ptr = 0; m_cnt = 0;
        v.avg = '0; v.valid = 1'b0; v.y = 1'b0;
        for (int n = 0; n < 80; n++) begin
            v.rst  = 1'b0;
            v.clr  = ($urandom_range(0, 19) == 0);
            v.load = ($urandom_range(0, 3) != 0);
            v.x    = 4'($urandom_range(0, 15));
            v.thr  = 4'($urandom_range(0, 15));
            if (v.clr) begin
                for (int i = 0; i < 4; i++) m_ring[i] = '0;
                m_ptr = 0; m_cnt = 0;
                v.avg = '0; v.valid = 1'b0; v.y = 1'b0;
            end else if (v.load) begin
                m_ring[m_ptr] = v.x;
                m_ptr = (m_ptr + 1) % 4;
                if (m_cnt < 4) m_cnt++;
                s = 0;
                for (int i = 0; i < 4; i++) s += int'(m_ring[i]);
                a = RND ? (s + 2) / 4 : s / 4;
                if (a > 15) a = 15;
                v.avg   = 4'(a);
                v.valid = (m_cnt == 4);
                v.y     = (a >= int'(v.thr));
            end
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
